// File: rtl/pool_fmap_buffer_if.sv
// Bus between the pooler/consumer side and the pooled feature-map buffer.
// Carries the pooler write strobes and the valid/ready drain channel.
interface pool_fmap_buffer_if #(
    parameter int unsigned N  = 16,
    parameter int unsigned AW = 4
);
    logic          ce;
    logic [N-1:0]  data_in;
    logic          valid_in;
    logic          end_in;
    logic [N-1:0]  rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic          rd_last;
    logic [AW-1:0] rd_row;
    logic [AW-1:0] rd_col;
    logic          busy;
    logic          ovf;

    // Buffer side: consumes pooler strobes, produces the drain stream.
    modport slave (
        input  ce, data_in, valid_in, end_in, rd_ready,
        output rd_data, rd_valid, rd_last, rd_row, rd_col, busy, ovf
    );

    // Environment side: pooler plus downstream consumer.
    modport master (
        output ce, data_in, valid_in, end_in, rd_ready,
        input  rd_data, rd_valid, rd_last, rd_row, rd_col, busy, ovf
    );
endinterface

// File: rtl/pool_fmap_buffer.sv
// Pooled feature-map buffer: captures one pooled frame from the pooler
// (ce/valid/end qualified), then drains it in raster order over valid/ready.
// Optional macro POOL_FMAP_BUF_RELU_EN clamps negative samples to zero on write.
module pool_fmap_buffer #(
    parameter int unsigned N    = 16,
    parameter int unsigned Q    = 12,
    parameter int unsigned M_IN = 12,
    parameter int unsigned P    = 3
) (
    input  logic              clk,
    input  logic              master_rst,
    pool_fmap_buffer_if.slave bus
);
    localparam int unsigned M_OUT    = M_IN / P;
    localparam int unsigned DEPTH    = M_OUT * M_OUT;
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned CW       = AW + 1;
    // Sign bit sits above the integer and fractional fields of the Q format.
    localparam int unsigned SIGN_BIT = (N - 1 - Q) + Q;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_ptr;
    logic [CW-1:0] frame_len;
    logic [N-1:0]  mem [DEPTH];

    logic [N-1:0]  rd_data;
    logic          rd_valid;
    logic          rd_last;
    logic [AW-1:0] rd_row;
    logic [AW-1:0] rd_col;
    logic          busy;
    logic          ovf;

    logic          wr_en_c;
    logic [CW-1:0] wr_next_c;
    logic          frame_done_c;
    logic [CW-1:0] rd_ptr_next_c;
    logic [N-1:0]  wr_data_c;

    // Write qualification, frame-close detection and next read pointer.
    always_comb begin
        wr_en_c       = (state == FILL) && bus.ce && bus.valid_in;
        wr_next_c     = wr_cnt + CW'(wr_en_c);
        frame_done_c  = (state == FILL) &&
                        ((wr_en_c && (wr_next_c == CW'(DEPTH))) ||
                         (bus.ce && bus.end_in && (wr_next_c != '0)));
        rd_ptr_next_c = rd_ptr + CW'(1);
    end

    // Stored word: optional fused ReLU, otherwise bit-exact.
    always_comb begin
`ifdef POOL_FMAP_BUF_RELU_EN
        wr_data_c = bus.data_in[SIGN_BIT] ? '0 : bus.data_in;
`else
        wr_data_c = {bus.data_in[SIGN_BIT], bus.data_in[SIGN_BIT-1:0]};
`endif
    end

    // Feature-map storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_cnt[AW-1:0]] <= wr_data_c;
        end
    end

    // Fill/drain controller with registered drain outputs.
    always_ff @(posedge clk or negedge master_rst) begin
        if (!master_rst) begin
            state     <= FILL;
            wr_cnt    <= '0;
            rd_ptr    <= '0;
            frame_len <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            rd_row    <= '0;
            rd_col    <= '0;
            busy      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    wr_cnt <= wr_next_c;
                    if (frame_done_c) begin
                        state     <= DRAIN;
                        frame_len <= wr_next_c;
                        rd_ptr    <= '0;
                        busy      <= 1'b1;
                    end
                end
                DRAIN: begin
                    // Samples arriving while draining are lost.
                    if (bus.ce && bus.valid_in) begin
                        ovf <= 1'b1;
                    end
                    if (!rd_valid) begin
                        // First beat of the frame, one cycle after entry.
                        rd_valid <= 1'b1;
                        rd_data  <= mem[0];
                        rd_row   <= '0;
                        rd_col   <= '0;
                        rd_last  <= (frame_len == CW'(1));
                    end else if (bus.rd_ready) begin
                        if (rd_last) begin
                            state    <= FILL;
                            rd_valid <= 1'b0;
                            rd_last  <= 1'b0;
                            busy     <= 1'b0;
                            wr_cnt   <= '0;
                            rd_ptr   <= '0;
                        end else begin
                            rd_ptr  <= rd_ptr_next_c;
                            rd_data <= mem[rd_ptr_next_c[AW-1:0]];
                            rd_last <= (rd_ptr_next_c == (frame_len - CW'(1)));
                            if (rd_col == AW'(M_OUT - 1)) begin
                                rd_col <= '0;
                                rd_row <= rd_row + AW'(1);
                            end else begin
                                rd_col <= rd_col + AW'(1);
                            end
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign bus.rd_data  = rd_data;
    assign bus.rd_valid = rd_valid;
    assign bus.rd_last  = rd_last;
    assign bus.rd_row   = rd_row;
    assign bus.rd_col   = rd_col;
    assign bus.busy     = busy;
    assign bus.ovf      = ovf;
endmodule

// File: doc/pool_fmap_buffer.md
Name: pool_fmap_buffer

Overview:
- Downstream neighbour of the pooling stage.
- Captures the pooled output stream, qualified by the pooler's valid/end strobes, into an on-chip feature-map buffer of (m/p)×(m/p) words.
- Once a frame is complete, drains the buffer to the next consumer (next conv layer loader / DMA) over a valid/ready handshake.
- Decouples the pooler's bursty, ce-gated output from a back-pressuring consumer.

Parameters:
- N, 16, data word width (Q-format fixed point, matches pooler).
- Q, 12, fractional bits (used only by the optional ReLU, sign test).
- M_IN, 12, input feature-map width fed to the pooler (m).
- P, 3, pool window size (p).
- M_OUT, M_IN/P = 4, pooled map width.
- DEPTH, M_OUT*M_OUT = 16, buffer entries.
- AW, clog2(DEPTH) = 4, address width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- master_rst  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable for the write side (same ce the pooler sees).
- data_in  in  N  pooled sample (pooler data_out).
- valid_in  in  1  sample-valid strobe (pooler valid_op).
- end_in  in  1  end-of-frame strobe (pooler end_op).
- rd_data  out  N  drained word.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  consumer accepts rd_data.
- rd_last  out  1  qualifies final word of frame.
- rd_row  out  AW  row index of current rd_data within the M_OUT×M_OUT map.
- rd_col  out  AW  column index of current rd_data.
- busy  out  1  high while in DRAIN.
- ovf  out  1  sticky: a sample arrived while draining or beyond DEPTH.

Behaviour:
- Reset (master_rst=0, async): FSM=FILL, wr_cnt=0, rd_ptr=0. All outputs 0: rd_data, rd_valid, rd_last, rd_row, rd_col, busy, ovf. Buffer contents undefined. Reset mid-drain aborts the frame immediately.
- Write acceptance: a write occurs when FSM=FILL && ce && valid_in. data_in goes to mem[wr_cnt]; wr_cnt increments. ce low blocks writes but does not stall the drain side.
- FILL→DRAIN, taken on the edge where either:
  - an accepted write makes wr_cnt reach DEPTH, or
  - ce && end_in is seen with wr_cnt (including a same-cycle write) ≥ 1.
  - frame_len latches the final count (1..DEPTH). A same-cycle valid_in+end_in write is included in the frame.
- end_in with zero words: stay in FILL, no drain, ovf unchanged.
- DRAIN:
  - busy=1.
  - rd_valid rises exactly 1 cycle after entering DRAIN, presenting mem[0] with rd_row=0, rd_col=0.
  - A beat transfers when rd_valid && rd_ready. The next word appears the following cycle, so back-to-back beats are possible with rd_ready held high.
  - While rd_valid && !rd_ready: rd_data, rd_row, rd_col and rd_last hold stable.
  - rd_col increments and wraps at M_OUT-1, incrementing rd_row.
  - rd_last=1 on the word with index frame_len-1.
- DRAIN→FILL: on the handshake of the rd_last beat. Next cycle: rd_valid=0, busy=0, wr_cnt=0, rd_ptr=0. The buffer accepts writes from that cycle on.
- Dropped writes: ce && valid_in during DRAIN is dropped and sets ovf. ovf clears only on reset.
- Widths: no arithmetic on data. Counters are AW+1 bits so DEPTH is representable.

Optional Feature:
- Macro POOL_FMAP_BUF_RELU_EN.
- Defined: on write, any data_in with MSB=1 (negative in signed Q(N-1-Q).Q) is stored as 0. Non-negative values are stored unchanged. Provides fused ReLU after average pooling.
- Undefined: data stored bit-exact. No extra logic.

Test Plan:
- Full frame: 16 writes of 0x0100..0x0F00+0x0100 at ce=1 with rd_ready=1 → rd_valid 1 cycle after 16th write. Output: 16 back-to-back beats in order, row/col stepping (0,0)..(3,3), rd_last on beat 16, busy falls after it.
- Back-pressure: rd_ready toggles 1,0,0,1 during drain → no beat lost or duplicated. rd_data/row/col stable while stalled. Sequence identical to the no-stall run.
- Early end: 5 writes with end_in on the 5th → exactly 5 beats, rd_last on the 5th (rd_row=1, rd_col=0). end_in with zero writes → no rd_valid, busy stays 0.
- Overflow: valid_in pulses during DRAIN → samples absent from output, ovf=1 and remains 1 through the next full frame until master_rst.
- Reset mid-drain: assert master_rst low after beat 7 → rd_valid/busy/ovf 0 immediately. A new 16-word frame afterwards drains correctly from index 0.
- RELU (macro defined): write 0xF800 and 0x0400 → read 0x0000 and 0x0400. Macro undefined → read 0xF800 and 0x0400.
